leitor_colisao: RTL and testbench
=================================

LEITOR_COLISAO -- requirements
Module: leitor_colisao

Interface
REQ-001 Parameter COMPRIMENTO, default 8, is the cell width in pixels.
REQ-002 Parameter ALTURA, default 8, is the cell height in pixels.
REQ-003 Parameter LARGURA_TELA, default 640, is the trail RAM row stride in pixels.
REQ-004 Parameters X_MIN=16, X_MAX=623, Y_MIN=16, Y_MAX=463 set the playfield limits (inclusive).
REQ-005 VGA_CLK  in  1  sole clock; all logic is on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 req  in  1  start a collision check; sampled only in IDLE.
REQ-008 pos_x  in  10  top-left x of the candidate cell.
REQ-009 pos_y  in  10  top-left y of the candidate cell.
REQ-010 ram_addr  out  19  trail RAM read address, equal to y*LARGURA_TELA + x.
REQ-011 ram_rd  out  1  read strobe; high only when ram_addr is a valid issued read.
REQ-012 ram_q  in  8  trail RAM data; valid exactly 1 cycle after the read is issued; 0 means an empty pixel.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse marking the result as valid.
REQ-015 colisao  out  1  check result; 1 means a hit.
REQ-016 borda  out  1  1 means the hit came from the playfield limits.
REQ-017 codigo  out  8  ram_q value of the first non-zero pixel; 0 when the hit is a border hit or there is no hit.

Function
REQ-018 States SHALL be IDLE, CHECK, READ and DONE.
REQ-019 IDLE with req=1 SHALL latch pos_x/pos_y, clear colisao/borda/codigo, and go to CHECK; call this cycle 0.
REQ-020 req SHALL be ignored in every state other than IDLE.
REQ-021 CHECK (cycle 1) SHALL compute the bounds in 11 bits with no wrap:
  - out of bounds when pos_x < X_MIN, pos_x+COMPRIMENTO-1 > X_MAX, pos_y < Y_MIN, or pos_y+ALTURA-1 > Y_MAX;
  - out of bounds: set colisao=1, borda=1, codigo=0, issue no RAM reads, and go to DONE;
  - otherwise: go to READ.
REQ-022 READ SHALL issue one read per cycle in row-major order: dx 0..COMPRIMENTO-1 inner, dy 0..ALTURA-1 outer.
REQ-023 Each read address SHALL be (pos_y+dy)*LARGURA_TELA + (pos_x+dx), computed at full 19-bit width.
REQ-024 Each returned sample SHALL be evaluated in the cycle its data is valid.
REQ-025 On the first non-zero sample: set colisao=1, borda=0, codigo=ram_q, stop issuing reads, discard any in-flight sample, and go to DONE.
REQ-026 With defaults and no hit, reads SHALL be issued in cycles 2..65 and evaluated in cycles 3..66, and the block SHALL enter DONE with colisao=0.
REQ-027 done SHALL be high for exactly the one cycle spent in DONE:
  - cycle 2 for a border hit;
  - cycle 4+k for a hit on sample k (k = 0..63);
  - cycle 67 for a clean check.
REQ-028 DONE SHALL return unconditionally to IDLE, so a req held high produces back-to-back checks with one IDLE cycle between them.
REQ-029 colisao, borda and codigo SHALL hold their value from DONE until the next accepted req.
REQ-030 ram_rd SHALL be low in IDLE, CHECK and DONE, and low in READ once a hit is detected.
REQ-031 ram_addr SHALL hold its last value whenever ram_rd is low.
REQ-032 Changes on pos_x/pos_y after acceptance SHALL NOT affect the check in progress.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE and drive ram_addr=0, ram_rd=0, busy=0, done=0, colisao=0, borda=0, codigo=0.
REQ-034 Assertion of reset mid-check SHALL abort the check with no done pulse and discard the in-flight read.
REQ-035 The first req after reset_n deasserts SHALL be accepted normally.

Verification
REQ-036 RAM all-zero, req with pos=(216,240): 64 reads, first ram_addr 153816, last 158303; done in cycle 67 with colisao=0, borda=0, codigo=0.
REQ-037 pos=(8,240): no ram_rd pulse; done in cycle 2 with colisao=1, borda=1, codigo=0.
REQ-038 pos=(1020,240): 11-bit bounds catches the overflow; done in cycle 2 with borda=1.
REQ-039 RAM address 156376 (dx=0, dy=4) = 0x80, pos=(216,240):
  - sample k=32 is the hit; done in cycle 36 with colisao=1, borda=0, codigo=0x80;
  - ram_rd is low from cycle 36 onward.
REQ-040 reset_n pulsed low in cycle 20 of a check: all outputs are 0 at once and no done pulse follows.
REQ-041 req held high for 200 cycles on clean RAM: done pulses in cycles 67 and 135.
REQ-042 req pulsed while busy: the request is ignored and the result is unchanged.

Source files
------------

// File: rtl/leitor_colisao.sv
// leitor_colisao: checks whether a COMPRIMENTO x ALTURA cell at (pos_x, pos_y) leaves the playfield or overlaps a trail pixel.
// Latency: done in cycle 2 (border hit), 4+k (hit on sample k) or 3+COMPRIMENTO*ALTURA (clean check), counted from the accepting cycle 0.
// Backpressure: none; req is only sampled in IDLE, and the trail RAM must return ram_q exactly one cycle after each ram_rd.
// Ports: VGA_CLK / reset_n (async, active-low); req, pos_x, pos_y start a check;
//        ram_addr, ram_rd, ram_q form the trail RAM read port;
//        busy, done, colisao, borda, codigo report status and the held result.
module leitor_colisao #(
  parameter int COMPRIMENTO  = 8,
  parameter int ALTURA       = 8,
  parameter int LARGURA_TELA = 640,
  parameter int X_MIN        = 16,
  parameter int X_MAX        = 623,
  parameter int Y_MIN        = 16,
  parameter int Y_MAX        = 463
) (
  input  logic        VGA_CLK,
  input  logic        reset_n,
  input  logic        req,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic [18:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_q,
  output logic        busy,
  output logic        done,
  output logic        colisao,
  output logic        borda,
  output logic [7:0]  codigo
);

  localparam int N_PIX = COMPRIMENTO * ALTURA;
  localparam int DXW   = (COMPRIMENTO > 1) ? $clog2(COMPRIMENTO) : 1;
  localparam int DYW   = (ALTURA > 1) ? $clog2(ALTURA) : 1;
  localparam int CW    = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, READ, DONE} estado_t;

  estado_t        estado, prox_estado;
  logic [9:0]     px, py;          // position latched at acceptance
  logic [DXW-1:0] dx, dx_nxt;      // offsets of the read currently on ram_addr
  logic [DYW-1:0] dy, dy_nxt;
  logic           amostra_vld;     // ram_q carries the sample of last cycle's read
  logic [CW-1:0]  cnt_aval;        // samples evaluated so far
  logic           ultimo_lido;
  logic           fora;
  logic           acerto;
  logic           fim_limpo;
  logic [18:0]    addr_nxt;
  logic [10:0]    x_hi, y_hi;

  // Bounds in 11 bits so a cell near x=1023 cannot wrap back into range.
  assign x_hi = {1'b0, px} + 11'(COMPRIMENTO - 1);
  assign y_hi = {1'b0, py} + 11'(ALTURA - 1);
  assign fora = ({1'b0, px} < 11'(X_MIN)) || (x_hi > 11'(X_MAX)) ||
                ({1'b0, py} < 11'(Y_MIN)) || (y_hi > 11'(Y_MAX));

  assign ultimo_lido = (dx == DXW'(COMPRIMENTO - 1)) && (dy == DYW'(ALTURA - 1));
  assign acerto      = (estado == READ) && amostra_vld && (ram_q != 8'h00);
  assign fim_limpo   = (estado == READ) && amostra_vld && (ram_q == 8'h00) &&
                       (cnt_aval == CW'(N_PIX - 1));

  // Row-major walk: CHECK seeds (0,0), READ steps dx then wraps into dy.
  always_comb begin
    dx_nxt = '0;
    dy_nxt = '0;
    if (estado == READ) begin
      if (dx == DXW'(COMPRIMENTO - 1)) begin
        dx_nxt = '0;
        dy_nxt = dy + 1'b1;
      end else begin
        dx_nxt = dx + 1'b1;
        dy_nxt = dy;
      end
    end
  end

  assign addr_nxt = (19'(py) + 19'(dy_nxt)) * 19'(LARGURA_TELA) + 19'(px) + 19'(dx_nxt);

  // State register
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) estado <= IDLE;
    else          estado <= prox_estado;
  end

  // Next-state logic
  always_comb begin
    prox_estado = estado;
    case (estado)
      IDLE:    if (req) prox_estado = CHECK;
      CHECK:   prox_estado = fora ? DONE : READ;
      READ:    if (acerto || fim_limpo) prox_estado = DONE;
      DONE:    prox_estado = IDLE;
      default: prox_estado = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (estado != IDLE);
    done = (estado == DONE);
  end

  // Datapath: latched position, read walk and held result
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      px          <= '0;
      py          <= '0;
      dx          <= '0;
      dy          <= '0;
      ram_addr    <= '0;
      ram_rd      <= 1'b0;
      amostra_vld <= 1'b0;
      cnt_aval    <= '0;
      colisao     <= 1'b0;
      borda       <= 1'b0;
      codigo      <= 8'h00;
    end else begin
      amostra_vld <= 1'b0;
      case (estado)
        IDLE: begin
          if (req) begin
            px      <= pos_x;
            py      <= pos_y;
            colisao <= 1'b0;
            borda   <= 1'b0;
            codigo  <= 8'h00;
          end
        end
        CHECK: begin
          if (fora) begin
            colisao <= 1'b1;
            borda   <= 1'b1;
            codigo  <= 8'h00;
          end else begin
            ram_rd   <= 1'b1;
            ram_addr <= addr_nxt;
            dx       <= '0;
            dy       <= '0;
            cnt_aval <= '0;
          end
        end
        READ: begin
          if (acerto) begin
            // Stop reading; the read issued this cycle is never evaluated.
            colisao <= 1'b1;
            borda   <= 1'b0;
            codigo  <= ram_q;
            ram_rd  <= 1'b0;
          end else begin
            amostra_vld <= ram_rd;
            if (amostra_vld) cnt_aval <= cnt_aval + 1'b1;
            if (ram_rd && !ultimo_lido) begin
              dx       <= dx_nxt;
              dy       <= dy_nxt;
              ram_addr <= addr_nxt;
              ram_rd   <= 1'b1;
            end else begin
              ram_rd <= 1'b0;
            end
          end
        end
        default: ram_rd <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_colisao.sv
// tb_leitor_colisao: scoreboard bench for leitor_colisao.
// Latency: expectations are timestamped in cycles from the accepting cycle 0.
// Backpressure: none; the bench RAM answers every read one cycle later.
module tb_leitor_colisao;

  logic        VGA_CLK;
  logic        reset_n;
  logic        req;
  logic [9:0]  pos_x, pos_y;
  logic [18:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        busy, done, colisao, borda;
  logic [7:0]  codigo;

  leitor_colisao dut (
    .VGA_CLK (VGA_CLK),
    .reset_n (reset_n),
    .req     (req),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .ram_addr(ram_addr),
    .ram_rd  (ram_rd),
    .ram_q   (ram_q),
    .busy    (busy),
    .done    (done),
    .colisao (colisao),
    .borda   (borda),
    .codigo  (codigo)
  );

  typedef struct {
    int         cyc;
    logic       col;
    logic       bor;
    logic [7:0] cod;
  } res_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   rdq[$];
  res_t dq[$];
  res_t ultimo;

  // Single-pixel trail RAM
  logic       hit_en   = 1'b0;
  int         hit_addr = 0;
  logic [7:0] hit_val  = 8'h00;

  function automatic logic [7:0] pix(int a);
    return (hit_en && a == hit_addr) ? hit_val : 8'h00;
  endfunction

  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  always @(posedge VGA_CLK) cyc++;

  always @(posedge VGA_CLK) ram_q <= ram_rd ? pix(int'(ram_addr)) : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model: pushes every expected read address and the result.
  task automatic model(input int x, input int y, input int c0);
    res_t r;
    int   hit;
    int   a;
    if (x < 16 || x + 7 > 623 || y < 16 || y + 7 > 463) begin
      r.cyc = c0 + 2; r.col = 1'b1; r.bor = 1'b1; r.cod = 8'h00;
    end else begin
      hit = -1;
      r.cod = 8'h00;
      for (int k = 0; k < 64; k++) begin
        a = (y + k / 8) * 640 + x + k % 8;
        rdq.push_back(a);
        // The read after the hit sample is still issued, then dropped.
        if (hit >= 0) break;
        if (pix(a) != 8'h00) begin
          hit = k;
          r.cod = pix(a);
        end
      end
      if (hit >= 0) begin
        r.cyc = c0 + 4 + hit; r.col = 1'b1; r.bor = 1'b0;
      end else begin
        r.cyc = c0 + 67; r.col = 1'b0; r.bor = 1'b0;
      end
    end
    dq.push_back(r);
  endtask

  // Monitor: compares reads and results as the DUT produces them.
  always @(negedge VGA_CLK) begin
    if (reset_n) begin
      if (ram_rd) begin
        if (rdq.size() != 0) chk("rd_addr", 32'(ram_addr), rdq.pop_front());
        else                 chk("rd_extra", 32'(ram_rd), 32'd0);
      end
      if (done) begin
        if (dq.size() != 0) begin
          ultimo = dq.pop_front();
          chk("done_cyc", cyc, ultimo.cyc);
          chk("colisao", 32'(colisao), 32'(ultimo.col));
          chk("borda", 32'(borda), 32'(ultimo.bor));
          chk("codigo", 32'(codigo), 32'(ultimo.cod));
        end else begin
          chk("done_extra", 32'(done), 32'd0);
        end
      end
    end
  end

  task automatic start(input int x, input int y);
    @(posedge VGA_CLK); #1;
    pos_x = 10'(x);
    pos_y = 10'(y);
    req   = 1'b1;
    model(x, y, cyc);
    @(posedge VGA_CLK); #1;
    req = 1'b0;
    @(negedge VGA_CLK);
    chk("busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dq.size() != 0 && n < budget) begin
      @(posedge VGA_CLK);
      n++;
    end
    chk("timeout", dq.size(), 0);
    chk("rd_left", rdq.size(), 0);
    repeat (3) @(negedge VGA_CLK);
    chk("hold_col", 32'(colisao), 32'(ultimo.col));
    chk("hold_bor", 32'(borda), 32'(ultimo.bor));
    chk("hold_cod", 32'(codigo), 32'(ultimo.cod));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int c0;
    reset_n = 1'b0;
    req     = 1'b0;
    pos_x   = '0;
    pos_y   = '0;
    repeat (3) @(posedge VGA_CLK);
    #1;
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_rd", 32'(ram_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_col", 32'(colisao), 32'd0);
    chk("rst_bor", 32'(borda), 32'd0);
    chk("rst_cod", 32'(codigo), 32'd0);
    reset_n = 1'b1;

    // Clean check, border cases, 11-bit overflow and inclusive limits
    start(216, 240);  wait_done(100);
    start(8, 240);    wait_done(100);
    start(1020, 240); wait_done(100);
    start(617, 240);  wait_done(100);
    start(216, 457);  wait_done(100);
    start(616, 456);  wait_done(100);
    start(16, 16);    wait_done(100);

    // Hit on sample 32 (dx=0, dy=4), then on the first and last samples
    hit_en = 1'b1; hit_addr = 156376; hit_val = 8'h80;
    start(216, 240);  wait_done(100);
    hit_addr = 153816; hit_val = 8'h3c;
    start(216, 240);  wait_done(100);
    hit_addr = 158303; hit_val = 8'h01;
    start(216, 240);  wait_done(100);

    // req and position changes while busy are ignored
    hit_addr = 156376; hit_val = 8'h80;
    start(216, 240);
    repeat (8) @(posedge VGA_CLK);
    #1;
    pos_x = 10'd8;
    req   = 1'b1;
    @(posedge VGA_CLK); #1;
    req   = 1'b0;
    wait_done(100);
    hit_en = 1'b0;

    // Reset in cycle 20 of a check: outputs clear at once, no done follows
    start(216, 240);
    c0 = cyc - 1;
    while (cyc < c0 + 20) @(posedge VGA_CLK);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_addr", 32'(ram_addr), 32'd0);
    chk("mid_rd", 32'(ram_rd), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_col", 32'(colisao), 32'd0);
    rdq.delete();
    dq.delete();
    @(posedge VGA_CLK); #1;
    reset_n = 1'b1;
    repeat (80) @(posedge VGA_CLK);

    // First req after reset is accepted normally
    hit_en = 1'b1; hit_addr = 153825; hit_val = 8'h55;
    start(216, 240);  wait_done(100);
    hit_en = 1'b0;

    // req held high for 200 cycles: accepted in cycles 0, 68 and 136
    @(posedge VGA_CLK); #1;
    pos_x = 10'd216;
    pos_y = 10'd240;
    req   = 1'b1;
    c0    = cyc;
    model(216, 240, c0);
    model(216, 240, c0 + 68);
    model(216, 240, c0 + 136);
    repeat (200) @(posedge VGA_CLK);
    #1;
    req = 1'b0;
    wait_done(100);

    chk("final_done_q", dq.size(), 0);
    chk("final_rd_q", rdq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule
